reg_file_bank: RTL and testbench

REG_FILE_BANK -- requirements
Module: reg_file_bank

---
 rtl/reg_file_bank.sv | 131 +++++++++++++
 tb/tb_reg_file_bank.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_bank.sv
// Dual-write, dual-read register bank with a dedicated flag register and a
// shadow copy reached through a sequenced one-register-per-cycle save/restore.
//
// state     | meaning
// ----------+------------------------------------------------
// S_IDLE    | normal access, writes and bypass enabled
// S_SAVE    | copying main[idx] into shadow[idx], writes dropped
// S_RESTORE | copying shadow[idx] into main[idx], writes dropped
module reg_file_bank #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 16,
   parameter int ZERO_R0 = 0,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we1,
   input  logic [AW-1:0]    wa1,
   input  logic [WIDTH-1:0] wd1,
   input  logic             we2,
   input  logic [AW-1:0]    wa2,
   input  logic [WIDTH-1:0] wd2,
   input  logic             wef,
   input  logic [WIDTH-1:0] wdf,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   output logic [WIDTH-1:0] rdf,
   input  logic             save_req,
   input  logic             restore_req,
   output logic             busy,
   output logic             done
);

   localparam logic [AW-1:0] FLAG = AW'(DEPTH - 1);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SAVE    = 2'd1;
   localparam logic [1:0] S_RESTORE = 2'd2;

   logic [1:0]       state_q;
   logic [AW-1:0]    idx_q;
   logic             done_q;
   logic [WIDTH-1:0] main_q   [DEPTH];
   logic [WIDTH-1:0] shadow_q [DEPTH];
   logic             wr_ok;

   assign busy  = (state_q != S_IDLE);
   assign done  = done_q;
   assign wr_ok = ~busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               idx_q <= '0;
               if (save_req)
                  state_q <= S_SAVE;
               else if (restore_req)
                  state_q <= S_RESTORE;
            end
            S_SAVE, S_RESTORE: begin
               // Stop on the last index rather than letting the counter wrap.
               if (idx_q == LAST) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            main_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ZERO_R0 != 0 && i == 0)
               main_q[i] <= '0;
            else if (state_q == S_RESTORE && idx_q == AW'(i))
               main_q[i] <= shadow_q[i];
            else if (wr_ok && wef && FLAG == AW'(i))
               main_q[i] <= wdf;
            else if (wr_ok && we2 && wa2 == AW'(i))
               main_q[i] <= wd2;
            else if (wr_ok && we1 && wa1 == AW'(i))
               main_q[i] <= wd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            shadow_q[i] <= '0;
      end else if (state_q == S_SAVE) begin
         shadow_q[idx_q] <= main_q[idx_q];
      end
   end

   // Bypass mirrors the write priority so a read sees what the edge will commit.
   function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
      if (ZERO_R0 != 0 && addr == '0)
         return '0;
      if (wr_ok && wef && addr == FLAG)
         return wdf;
      if (wr_ok && we2 && wa2 == addr)
         return wd2;
      if (wr_ok && we1 && wa1 == addr)
         return wd1;
      return main_q[addr];
   endfunction

   always_comb begin
      rd1 = read_port(ra1);
      rd2 = read_port(ra2);
      rdf = read_port(FLAG);
   end

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed bench for reg_file_bank: expected values are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_reg_file_bank;

   logic        clk;
   logic        reset;
   logic        we1, we2, wef;
   logic [3:0]  wa1, wa2, ra1, ra2;
   logic [15:0] wd1, wd2, wdf;
   logic        save_req, restore_req;
   logic [15:0] rd1, rd2, rdf;
   logic        busy, done;
   logic [15:0] rd1_z, rd2_z, rdf_z;
   logic        busy_z, done_z;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   reg_file_bank #(.WIDTH(16), .DEPTH(16), .ZERO_R0(0)) dut (
      .clk(clk), .reset(reset),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .we2(we2), .wa2(wa2), .wd2(wd2),
      .wef(wef), .wdf(wdf),
      .ra1(ra1), .ra2(ra2),
      .rd1(rd1), .rd2(rd2), .rdf(rdf),
      .save_req(save_req), .restore_req(restore_req),
      .busy(busy), .done(done)
   );

   reg_file_bank #(.WIDTH(16), .DEPTH(16), .ZERO_R0(1)) dut_z (
      .clk(clk), .reset(reset),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .we2(we2), .wa2(wa2), .wd2(wd2),
      .wef(wef), .wdf(wdf),
      .ra1(ra1), .ra2(ra2),
      .rd1(rd1_z), .rd2(rd2_z), .rdf(rdf_z),
      .save_req(save_req), .restore_req(restore_req),
      .busy(busy_z), .done(done_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input logic [15:0] obs);
      exp_t e;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed %h expected none", obs);
         return;
      end
      e = exp_q.pop_front();
      checks++;
      assert (obs === e.val) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic wr1(input logic [3:0] a, input logic [15:0] d);
      we1 = 1'b1; wa1 = a; wd1 = d;
      tick();
      we1 = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      we1 = 0; we2 = 0; wef = 0;
      wa1 = 0; wa2 = 0; wd1 = 0; wd2 = 0; wdf = 0;
      ra1 = 4'd3; ra2 = 4'd4;
      save_req = 0; restore_req = 0;

      // reset state of both builds
      push("rst_rd1", 16'h0); push("rst_rd2", 16'h0); push("rst_rdf", 16'h0);
      push("rst_busy", 16'h0); push("rst_done", 16'h0);
      push("rst_z_rd2", 16'h0); push("rst_z_rdf", 16'h0);
      push("rst_z_busy", 16'h0); push("rst_z_done", 16'h0);
      repeat (3) @(posedge clk);
      #4;
      pop_check(rd1); pop_check(rd2); pop_check(rdf);
      pop_check({15'b0, busy}); pop_check({15'b0, done});
      pop_check(rd2_z); pop_check(rdf_z);
      pop_check({15'b0, busy_z}); pop_check({15'b0, done_z});
      reset = 1'b0;
      tick();

      // port collision: port 2 wins, bypass and commit
      we1 = 1; wa1 = 4'd3; wd1 = 16'h1234;
      we2 = 1; wa2 = 4'd3; wd2 = 16'hABCD;
      ra1 = 4'd3; ra2 = 4'd5;
      push("coll_bypass", 16'hABCD); push("coll_other_addr", 16'h0);
      settle(); pop_check(rd1); pop_check(rd2);
      tick();
      we1 = 0; we2 = 0;
      push("coll_commit", 16'hABCD);
      settle(); pop_check(rd1);

      // single port-1 write seen on read port 2
      we1 = 1; wa1 = 4'd4; wd1 = 16'h4444; ra2 = 4'd4;
      push("p1_bypass", 16'h4444);
      settle(); pop_check(rd2);
      tick();
      we1 = 0;
      push("p1_commit", 16'h4444);
      settle(); pop_check(rd2);

      // flag write beats port 1 on register 15
      wef = 1; wdf = 16'h0005;
      we1 = 1; wa1 = 4'd15; wd1 = 16'hFFFF; ra1 = 4'd15;
      push("flag_bypass_rdf", 16'h0005); push("flag_bypass_rd1", 16'h0005);
      settle(); pop_check(rdf); pop_check(rd1);
      tick();
      wef = 0; we1 = 0;
      push("flag_commit_rdf", 16'h0005); push("flag_commit_rd1", 16'h0005);
      settle(); pop_check(rdf); pop_check(rd1);

      // fill and save
      for (int i = 0; i < 16; i++) wr1(4'(i), 16'h0100 + 16'(i));
      ra1 = 4'd7;
      push("fill_r7", 16'h0107);
      settle(); pop_check(rd1);
      tick();
      save_req = 1;
      tick();
      save_req = 0;
      for (int k = 0; k < 16; k++) begin
         if (k == 3) begin
            we1 = 1; wa1 = 4'd2; wd1 = 16'h7777; ra1 = 4'd2;
            push("busy_no_bypass", 16'h0102);
         end
         push("save_busy", 16'h1); push("save_no_done", 16'h0);
         settle();
         if (k == 3) pop_check(rd1);
         pop_check({15'b0, busy}); pop_check({15'b0, done});
         tick();
         we1 = 0;
      end
      push("save_done", 16'h1); push("save_idle", 16'h0);
      settle(); pop_check({15'b0, done}); pop_check({15'b0, busy});
      tick();
      push("save_done_single", 16'h0);
      settle(); pop_check({15'b0, done});

      // clear main, then restore
      for (int i = 0; i < 16; i++) wr1(4'(i), 16'h0000);
      ra1 = 4'd7;
      push("cleared_r7", 16'h0);
      settle(); pop_check(rd1);
      tick();
      restore_req = 1;
      tick();
      restore_req = 0;
      for (int k = 0; k < 16; k++) begin
         push("restore_busy", 16'h1);
         settle(); pop_check({15'b0, busy});
         tick();
      end
      push("restore_done", 16'h1);
      settle(); pop_check({15'b0, done});
      for (int i = 0; i < 16; i++) begin
         ra1 = 4'(i);
         push("restored_reg", 16'h0100 + 16'(i));
         if (i < 2) push("z_restored_reg", (i == 0) ? 16'h0 : 16'h0101);
         #1;
         pop_check(rd1);
         if (i < 2) pop_check(rd1_z);
      end
      tick();

      // simultaneous requests: save wins
      wr1(4'd1, 16'hAAAA);
      save_req = 1; restore_req = 1;
      tick();
      save_req = 0; restore_req = 0;
      repeat (16) tick();
      ra1 = 4'd1;
      push("both_req_done", 16'h1); push("both_req_main_kept", 16'hAAAA);
      settle(); pop_check({15'b0, done}); pop_check(rd1);
      tick();
      wr1(4'd1, 16'h0000);
      restore_req = 1;
      tick();
      restore_req = 0;
      repeat (16) tick();
      push("both_req_shadow_saved", 16'hAAAA);
      settle(); pop_check(rd1);
      tick();

      // reset at copy index 7 of a restore
      ra1 = 4'd3; ra2 = 4'd4;
      restore_req = 1;
      tick();
      restore_req = 0;
      repeat (7) tick();
      push("abort_rd1", 16'h0); push("abort_rd2", 16'h0); push("abort_rdf", 16'h0);
      push("abort_busy", 16'h0); push("abort_done", 16'h0);
      reset = 1'b1;
      #1;
      pop_check(rd1); pop_check(rd2); pop_check(rdf);
      pop_check({15'b0, busy}); pop_check({15'b0, done});
      repeat (2) tick();
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         push("abort_no_done", 16'h0);
         settle(); pop_check({15'b0, done});
         tick();
      end

      // reset also cleared the shadow
      wr1(4'd3, 16'h3333);
      restore_req = 1;
      tick();
      restore_req = 0;
      repeat (16) tick();
      ra1 = 4'd3;
      push("shadow_cleared_done", 16'h1); push("shadow_cleared_r3", 16'h0);
      settle(); pop_check({15'b0, done}); pop_check(rd1);
      tick();

      // hardwired register 0
      we1 = 1; wa1 = 4'd0; wd1 = 16'h9999; ra1 = 4'd0;
      push("z_r0_bypass", 16'h0); push("nz_r0_bypass", 16'h9999);
      settle(); pop_check(rd1_z); pop_check(rd1);
      tick();
      we1 = 0;
      push("z_r0_commit", 16'h0); push("nz_r0_commit", 16'h9999);
      settle(); pop_check(rd1_z); pop_check(rd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
